fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Sequencing controller for the two-wide fetch unit. It turns redirect requests from commit, execute and decode into fetch's `fetch_en`, `stall`, `redirect_en` and `redirect_pc` inputs. It also holds the front-end in a fixed-length flush window after every redirect and limits outstanding fetch bundles with a credit counter sized to the decode queue. It sits between the backend redirect sources and `fetch`, and drives `flush_o` to the decode queue.

## Interface
- `PC_W`, 32, PC width.
- `TAG_W`, 7, ROB tag width including MSB wrap bit.
- `FQ_DEPTH`, 8, decode queue depth in bundles; also the credit count.
- `FLUSH_CYC`, 2, flush window length in cycles, ≥1.
- `RESET_PC`, 32'h0, boot fetch address.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `boot_go` in 1: leave IDLE.
- `halt_req` in 1: committed halt; stop fetching.
- `cm_redir_valid` in 1, `cm_redir_pc` in PC_W: trap/exception redirect from commit.
- `ex_redir_valid` in 1, `ex_redir_pc` in PC_W, `ex_redir_tag` in TAG_W: branch mispredict.
- `de_redir_valid` in 1, `de_redir_pc` in PC_W: decode-resolved unconditional branch.
- `fq_pop` in 1: decode queue consumed one bundle.
- `fetch_en` out 1, `stall` out 1, `redirect_en` out 1, `redirect_pc` out PC_W: to fetch.
- `flush_o` out 1: decode queue and in-flight bundles are discarded.
- `ctrl_state` out 2: IDLE=0, RUN=1, FLUSH=2, HALT=3.
- `credit_err` out 1: sticky flag for a pop with full credits.
- `redir_cnt` out 16: saturating count of accepted redirects.

## Operation
- FSM transitions:
  - IDLE→FLUSH on `boot_go`, with `redirect_pc`=RESET_PC.
  - RUN→FLUSH on any accepted redirect.
  - RUN→HALT on `halt_req` when no redirect is accepted.
  - FLUSH→RUN when the flush counter expires.
  - HALT→FLUSH on `cm_redir_valid` only.
- Redirect priority in RUN: cm > ex > de. `halt_req` loses to cm and ex, and beats de.
- Redirect handling in FLUSH:
  - cm is always accepted and restarts the window.
  - ex is accepted only if its tag is older than the latched tag. Older(a,b) = MSB of (a−b mod 2^TAG_W) = 1.
  - de is ignored.
  - A latched tag exists only when the window was opened by ex. Otherwise ex is ignored in FLUSH.
- Accepted redirect:
  - Latch the pc (and tag if from ex).
  - Set flush counter = FLUSH_CYC.
  - Increment `redir_cnt`, saturating at 16'hFFFF. The boot redirect does not count.
- Credits:
  - Reset value is FQ_DEPTH.
  - Each cycle with `fetch_en`=1 and `stall`=0 is one issue, which takes one credit.
  - Each `fq_pop` outside FLUSH returns one credit.
  - Issue and pop in the same cycle leave the count unchanged.
  - A pop at FQ_DEPTH with no issue is ignored and sets `credit_err`.
  - On the last FLUSH cycle, credits are set to FQ_DEPTH.
- Output decode (all outputs registered):
  - `fetch_en`=1 in RUN.
  - `stall`=1 in RUN when credits==0.
  - `flush_o`=1 in every FLUSH cycle.
  - In IDLE and HALT, `fetch_en`=`stall`=0.

## Timing
- Reset values:
  - state IDLE, credits FQ_DEPTH.
  - `fetch_en`, `stall`, `redirect_en`, `flush_o`, `credit_err` = 0.
  - `redirect_pc`=RESET_PC, `redir_cnt`=0, `ctrl_state`=0.
- Redirect sampled in cycle N:
  - Cycle N+1: `redirect_en`=1 for exactly one cycle with the new `redirect_pc`, and `flush_o`=1.
  - Cycles N+1..N+FLUSH_CYC: `flush_o`=1, `fetch_en`=0.
  - Cycle N+FLUSH_CYC+1: `fetch_en`=1, credits=FQ_DEPTH.
- A new cm redirect accepted in FLUSH at cycle M:
  - Pulses `redirect_en` again at M+1.
  - Window ends at M+FLUSH_CYC.
- A qualifying older ex redirect accepted in FLUSH follows the same timing.
- `halt_req` at N: `fetch_en`=0 from N+1.
- Credits reach 0 at N: `stall`=1 at N+1, deasserting the cycle after the next pop.
- Reset mid-FLUSH returns to IDLE immediately and drops the pending redirect.

## Structure
- `core_pkg` gets:
  - `fetch_ctrl_state_t` enum.
  - `RESET_PC` default constant.
  - `tag_older()` function, reused by the ROB and branch unit.
- One sub-module, `redir_arb`: combinational priority and age arbiter. Outputs accept, source, pc and tag.
- Counters and FSM live in `fetch_ctrl`.

## Test plan
- Boot:
  - Stimulus: reset, then `boot_go` at cycle 3.
  - Required: `redirect_en`=1 with pc 0x0 at cycle 4; `flush_o` at 4–5; `fetch_en`=1 at 6; `redir_cnt`=0.
- Credits:
  - Stimulus: no pops for 8 issue cycles; then `fq_pop` for one cycle.
  - Required: `stall`=1 once credits hit 0; `stall`=0 one cycle after the pop; exactly 1 further issue.
- Priority:
  - Stimulus: cm (pc 0x100), ex (0x200) and de (0x300) all in the same RUN cycle.
  - Required: `redirect_pc`=0x100; `redir_cnt`=1.
- Age:
  - Stimulus: ex tag 0x05 opens FLUSH; ex tag 0x7E arrives next cycle.
  - Required: 0x7E is older across the wrap, so a second `redirect_en` pulse fires. A later tag 0x06 is ignored.
- Halt:
  - Stimulus: `halt_req` in RUN; later, `de_redir_valid` arrives, then `cm_redir_valid` pc 0x40.
  - Required: `ctrl_state`=3 and `fetch_en`=0; the de redirect is ignored; the cm redirect gives FLUSH then RUN with pc 0x40.
- Error and reset:
  - Stimulus: `fq_pop` at full credits, then reset asserted mid-FLUSH.
  - Required: `credit_err`=1 after the pop. After reset: `credit_err`=0, `ctrl_state`=0, `flush_o`=0 immediately.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core types and helpers.
// Used by the fetch controller, ROB and branch unit.
package core_pkg;

    typedef enum logic [1:0] {
        FC_IDLE  = 2'd0,
        FC_RUN   = 2'd1,
        FC_FLUSH = 2'd2,
        FC_HALT  = 2'd3
    } fetch_ctrl_state_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_CM   = 2'd1,
        SRC_EX   = 2'd2,
        SRC_DE   = 2'd3
    } redir_src_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0;
    localparam int          TAG_W_DEFAULT    = 7;

    // a is older than b when (a - b) mod 2^w has its MSB set
    function automatic logic tag_older(
        input logic [31:0] a,
        input logic [31:0] b,
        input int          w
    );
        logic [31:0] d;
        d = (a - b) >> (w - 1);
        return |(d & 32'd1);
    endfunction

endpackage

// File: rtl/redir_arb.sv
// Redirect priority and age arbiter.
// Purely combinational; the controller registers the result.
module redir_arb
    import core_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int TAG_W = TAG_W_DEFAULT
) (
    input  fetch_ctrl_state_t state_i,
    input  logic              halt_i,
    input  logic              cm_valid_i,
    input  logic [PC_W-1:0]   cm_pc_i,
    input  logic              ex_valid_i,
    input  logic [PC_W-1:0]   ex_pc_i,
    input  logic [TAG_W-1:0]  ex_tag_i,
    input  logic              de_valid_i,
    input  logic [PC_W-1:0]   de_pc_i,
    input  logic              tag_vld_i,
    input  logic [TAG_W-1:0]  tag_i,
    output logic              accept_o,
    output redir_src_t        src_o,
    output logic [PC_W-1:0]   pc_o,
    output logic [TAG_W-1:0]  tag_o
);

    logic ex_older;

    assign ex_older = tag_vld_i &&
        tag_older(32'(ex_tag_i), 32'(tag_i), TAG_W);

    // Pick one redirect source according to the current state
    always_comb begin
        src_o = SRC_NONE;
        unique case (state_i)
            FC_RUN: begin
                if (cm_valid_i) begin
                    src_o = SRC_CM;
                end else if (ex_valid_i) begin
                    src_o = SRC_EX;
                end else if (de_valid_i && !halt_i) begin
                    src_o = SRC_DE;
                end
            end
            FC_FLUSH: begin
                if (cm_valid_i) begin
                    src_o = SRC_CM;
                end else if (ex_valid_i && ex_older) begin
                    src_o = SRC_EX;
                end
            end
            FC_HALT: begin
                if (cm_valid_i) begin
                    src_o = SRC_CM;
                end
            end
            default: src_o = SRC_NONE;
        endcase
    end

    // Route the winning pc; the tag only matters for ex
    always_comb begin
        pc_o  = '0;
        tag_o = ex_tag_i;
        unique case (src_o)
            SRC_CM:  pc_o = cm_pc_i;
            SRC_EX:  pc_o = ex_pc_i;
            SRC_DE:  pc_o = de_pc_i;
            default: pc_o = '0;
        endcase
    end

    assign accept_o = (src_o != SRC_NONE);

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencing controller: redirects, flush window,
// and decode-queue credit flow control for the fetch unit.
module fetch_ctrl
    import core_pkg::*;
#(
    parameter int              PC_W      = 32,
    parameter int              TAG_W     = TAG_W_DEFAULT,
    parameter int              FQ_DEPTH  = 8,
    parameter int              FLUSH_CYC = 2,
    parameter logic [PC_W-1:0] RESET_PC  = PC_W'(RESET_PC_DEFAULT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             boot_go,
    input  logic             halt_req,
    input  logic             cm_redir_valid,
    input  logic [PC_W-1:0]  cm_redir_pc,
    input  logic             ex_redir_valid,
    input  logic [PC_W-1:0]  ex_redir_pc,
    input  logic [TAG_W-1:0] ex_redir_tag,
    input  logic             de_redir_valid,
    input  logic [PC_W-1:0]  de_redir_pc,
    input  logic             fq_pop,
    output logic             fetch_en,
    output logic             stall,
    output logic             redirect_en,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             flush_o,
    output logic [1:0]       ctrl_state,
    output logic             credit_err,
    output logic [15:0]      redir_cnt
);

    localparam int FC_W = (FLUSH_CYC < 2) ? 1 : $clog2(FLUSH_CYC + 1);
    localparam int CR_W = $clog2(FQ_DEPTH + 1);
    localparam logic [FC_W-1:0] FC_INIT = FC_W'(FLUSH_CYC);
    localparam logic [CR_W-1:0] CR_FULL = CR_W'(FQ_DEPTH);

    fetch_ctrl_state_t state_q, state_d;
    logic [FC_W-1:0]   cnt_q, cnt_d;
    logic [CR_W-1:0]   credits_q, credits_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              tag_vld_q, tag_vld_d;
    logic              redir_en_q, redir_en_d;
    logic              fetch_en_q, stall_q, flush_q;
    logic              err_q, err_d;
    logic [15:0]       rcnt_q, rcnt_d;
    logic              bump;

    logic              arb_accept;
    redir_src_t        arb_src;
    logic [PC_W-1:0]   arb_pc;
    logic [TAG_W-1:0]  arb_tag;
    logic              issue;
    logic              pop_eff;

    redir_arb #(
        .PC_W  (PC_W),
        .TAG_W (TAG_W)
    ) u_arb (
        .state_i    (state_q),
        .halt_i     (halt_req),
        .cm_valid_i (cm_redir_valid),
        .cm_pc_i    (cm_redir_pc),
        .ex_valid_i (ex_redir_valid),
        .ex_pc_i    (ex_redir_pc),
        .ex_tag_i   (ex_redir_tag),
        .de_valid_i (de_redir_valid),
        .de_pc_i    (de_redir_pc),
        .tag_vld_i  (tag_vld_q),
        .tag_i      (tag_q),
        .accept_o   (arb_accept),
        .src_o      (arb_src),
        .pc_o       (arb_pc),
        .tag_o      (arb_tag)
    );

    // Next state, flush window and redirect latch
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_d       = pc_q;
        tag_d      = tag_q;
        tag_vld_d  = tag_vld_q;
        redir_en_d = 1'b0;
        bump       = 1'b0;
        if (arb_accept) begin
            state_d    = FC_FLUSH;
            cnt_d      = FC_INIT;
            pc_d       = arb_pc;
            tag_d      = arb_tag;
            tag_vld_d  = (arb_src == SRC_EX);
            redir_en_d = 1'b1;
            bump       = 1'b1;
        end else begin
            unique case (state_q)
                FC_IDLE: begin
                    if (boot_go) begin
                        state_d    = FC_FLUSH;
                        cnt_d      = FC_INIT;
                        pc_d       = RESET_PC;
                        tag_vld_d  = 1'b0;
                        redir_en_d = 1'b1;
                    end
                end
                FC_RUN: begin
                    if (halt_req) begin
                        state_d = FC_HALT;
                    end
                end
                FC_FLUSH: begin
                    if (cnt_q <= FC_W'(1)) begin
                        state_d = FC_RUN;
                    end else begin
                        cnt_d = cnt_q - FC_W'(1);
                    end
                end
                FC_HALT: state_d = FC_HALT;
                default: state_d = FC_IDLE;
            endcase
        end
    end

    assign issue   = fetch_en_q && !stall_q;
    assign pop_eff = fq_pop && (state_q != FC_FLUSH);

    // Credit counter, sticky error and redirect statistics
    always_comb begin
        credits_d = credits_q;
        err_d     = err_q;
        rcnt_d    = rcnt_q;
        if (state_q == FC_FLUSH && state_d == FC_RUN) begin
            credits_d = CR_FULL;
        end else if (issue && !pop_eff) begin
            credits_d = credits_q - CR_W'(1);
        end else if (pop_eff && !issue) begin
            if (credits_q == CR_FULL) begin
                err_d = 1'b1;
            end else begin
                credits_d = credits_q + CR_W'(1);
            end
        end
        if (bump && rcnt_q != 16'hFFFF) begin
            rcnt_d = rcnt_q + 16'd1;
        end
    end

    // State, counters and registered fetch-side outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= FC_IDLE;
            cnt_q      <= '0;
            credits_q  <= CR_FULL;
            pc_q       <= RESET_PC;
            tag_q      <= '0;
            tag_vld_q  <= 1'b0;
            redir_en_q <= 1'b0;
            fetch_en_q <= 1'b0;
            stall_q    <= 1'b0;
            flush_q    <= 1'b0;
            err_q      <= 1'b0;
            rcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            credits_q  <= credits_d;
            pc_q       <= pc_d;
            tag_q      <= tag_d;
            tag_vld_q  <= tag_vld_d;
            redir_en_q <= redir_en_d;
            fetch_en_q <= (state_d == FC_RUN);
            stall_q    <= (state_d == FC_RUN) && (credits_d == '0);
            flush_q    <= (state_d == FC_FLUSH);
            err_q      <= err_d;
            rcnt_q     <= rcnt_d;
        end
    end

    assign fetch_en    = fetch_en_q;
    assign stall       = stall_q;
    assign redirect_en = redir_en_q;
    assign redirect_pc = pc_q;
    assign flush_o     = flush_q;
    assign ctrl_state  = state_q;
    assign credit_err  = err_q;
    assign redir_cnt   = rcnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl.
// Hand-computed expectations, cycle-by-cycle.
module tb_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        boot_go;
    logic        halt_req;
    logic        cm_redir_valid;
    logic [31:0] cm_redir_pc;
    logic        ex_redir_valid;
    logic [31:0] ex_redir_pc;
    logic [6:0]  ex_redir_tag;
    logic        de_redir_valid;
    logic [31:0] de_redir_pc;
    logic        fq_pop;
    logic        fetch_en;
    logic        stall;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        flush_o;
    logic [1:0]  ctrl_state;
    logic        credit_err;
    logic [15:0] redir_cnt;

    int n_chk;
    int n_fail;
    int issues;

    fetch_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .boot_go        (boot_go),
        .halt_req       (halt_req),
        .cm_redir_valid (cm_redir_valid),
        .cm_redir_pc    (cm_redir_pc),
        .ex_redir_valid (ex_redir_valid),
        .ex_redir_pc    (ex_redir_pc),
        .ex_redir_tag   (ex_redir_tag),
        .de_redir_valid (de_redir_valid),
        .de_redir_pc    (de_redir_pc),
        .fq_pop         (fq_pop),
        .fetch_en       (fetch_en),
        .stall          (stall),
        .redirect_en    (redirect_en),
        .redirect_pc    (redirect_pc),
        .flush_o        (flush_o),
        .ctrl_state     (ctrl_state),
        .credit_err     (credit_err),
        .redir_cnt      (redir_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_eq(
        input string       tag,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk          = 0;
        n_fail         = 0;
        reset          = 1'b1;
        boot_go        = 1'b0;
        halt_req       = 1'b0;
        cm_redir_valid = 1'b0;
        cm_redir_pc    = '0;
        ex_redir_valid = 1'b0;
        ex_redir_pc    = '0;
        ex_redir_tag   = '0;
        de_redir_valid = 1'b0;
        de_redir_pc    = '0;
        fq_pop         = 1'b0;
        #12;
        expect_eq("rst_state", 32'(ctrl_state), 32'd0);
        expect_eq("rst_fetch", 32'(fetch_en), 32'd0);
        expect_eq("rst_stall", 32'(stall), 32'd0);
        expect_eq("rst_redir", 32'(redirect_en), 32'd0);
        expect_eq("rst_flush", 32'(flush_o), 32'd0);
        expect_eq("rst_pc", redirect_pc, 32'h0);
        expect_eq("rst_cnt", 32'(redir_cnt), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        // cycle 0
        tick();
        tick();
        tick();
        // cycle 3: boot
        boot_go = 1'b1;
        tick();
        // cycle 4
        boot_go = 1'b0;
        expect_eq("boot_redir", 32'(redirect_en), 32'd1);
        expect_eq("boot_pc", redirect_pc, 32'h0);
        expect_eq("boot_flush4", 32'(flush_o), 32'd1);
        expect_eq("boot_fe4", 32'(fetch_en), 32'd0);
        expect_eq("boot_st4", 32'(ctrl_state), 32'd2);
        tick();
        // cycle 5
        expect_eq("boot_flush5", 32'(flush_o), 32'd1);
        expect_eq("boot_pulse", 32'(redirect_en), 32'd0);
        expect_eq("boot_fe5", 32'(fetch_en), 32'd0);
        tick();
        // cycle 6
        expect_eq("boot_fe6", 32'(fetch_en), 32'd1);
        expect_eq("boot_flush6", 32'(flush_o), 32'd0);
        expect_eq("boot_st6", 32'(ctrl_state), 32'd1);
        expect_eq("boot_cnt", 32'(redir_cnt), 32'd0);
        // credits: cycles 6..15 with no pops
        issues = 0;
        for (int i = 0; i < 10; i++) begin
            if (fetch_en && !stall) issues++;
            tick();
        end
        // cycle 16
        expect_eq("cr_issues", 32'(issues), 32'd8);
        expect_eq("cr_stall", 32'(stall), 32'd1);
        fq_pop = 1'b1;
        tick();
        // cycle 17
        fq_pop = 1'b0;
        expect_eq("cr_unstall", 32'(stall), 32'd0);
        issues = 0;
        for (int i = 0; i < 4; i++) begin
            if (fetch_en && !stall) issues++;
            tick();
        end
        // cycle 21
        expect_eq("cr_one_more", 32'(issues), 32'd1);
        expect_eq("cr_restall", 32'(stall), 32'd1);
        // priority: cm > ex > de
        cm_redir_valid = 1'b1;
        cm_redir_pc    = 32'h100;
        ex_redir_valid = 1'b1;
        ex_redir_pc    = 32'h200;
        ex_redir_tag   = 7'h10;
        de_redir_valid = 1'b1;
        de_redir_pc    = 32'h300;
        tick();
        // cycle 22
        cm_redir_valid = 1'b0;
        ex_redir_valid = 1'b0;
        de_redir_valid = 1'b0;
        expect_eq("pri_redir", 32'(redirect_en), 32'd1);
        expect_eq("pri_pc", redirect_pc, 32'h100);
        expect_eq("pri_cnt", 32'(redir_cnt), 32'd1);
        tick();
        tick();
        // cycle 24
        expect_eq("pri_run", 32'(ctrl_state), 32'd1);
        expect_eq("pri_reload", 32'(stall), 32'd0);
        // age: ex tag 0x05 opens the window
        ex_redir_valid = 1'b1;
        ex_redir_pc    = 32'h500;
        ex_redir_tag   = 7'h05;
        tick();
        // cycle 25
        expect_eq("age_pc1", redirect_pc, 32'h500);
        expect_eq("age_st1", 32'(ctrl_state), 32'd2);
        ex_redir_pc  = 32'h7E0;
        ex_redir_tag = 7'h7E;
        tick();
        // cycle 26
        expect_eq("age_pulse2", 32'(redirect_en), 32'd1);
        expect_eq("age_pc2", redirect_pc, 32'h7E0);
        expect_eq("age_cnt2", 32'(redir_cnt), 32'd3);
        ex_redir_pc  = 32'h600;
        ex_redir_tag = 7'h06;
        tick();
        // cycle 27
        ex_redir_valid = 1'b0;
        expect_eq("age_young", 32'(redirect_en), 32'd0);
        expect_eq("age_pc3", redirect_pc, 32'h7E0);
        expect_eq("age_cnt3", 32'(redir_cnt), 32'd3);
        expect_eq("age_flush", 32'(flush_o), 32'd1);
        tick();
        // cycle 28: halt beats de
        expect_eq("age_run", 32'(fetch_en), 32'd1);
        halt_req       = 1'b1;
        de_redir_valid = 1'b1;
        de_redir_pc    = 32'h900;
        tick();
        // cycle 29
        halt_req    = 1'b0;
        de_redir_pc = 32'h300;
        expect_eq("halt_st", 32'(ctrl_state), 32'd3);
        expect_eq("halt_fe", 32'(fetch_en), 32'd0);
        expect_eq("halt_nored", 32'(redirect_en), 32'd0);
        tick();
        // cycle 30
        de_redir_valid = 1'b0;
        expect_eq("halt_de_st", 32'(ctrl_state), 32'd3);
        expect_eq("halt_de_cnt", 32'(redir_cnt), 32'd3);
        cm_redir_valid = 1'b1;
        cm_redir_pc    = 32'h40;
        tick();
        // cycle 31
        cm_redir_valid = 1'b0;
        expect_eq("halt_cm_st", 32'(ctrl_state), 32'd2);
        expect_eq("halt_cm_pc", redirect_pc, 32'h40);
        expect_eq("halt_cm_red", 32'(redirect_en), 32'd1);
        tick();
        tick();
        // cycle 33
        expect_eq("halt_rerun", 32'(ctrl_state), 32'd1);
        expect_eq("halt_cm_cnt", 32'(redir_cnt), 32'd4);
        halt_req = 1'b1;
        tick();
        // cycle 34: 7 credits, pop back to 8
        halt_req = 1'b0;
        fq_pop   = 1'b1;
        tick();
        // cycle 35: pop at full credits
        expect_eq("err_clear", 32'(credit_err), 32'd0);
        tick();
        // cycle 36
        fq_pop = 1'b0;
        expect_eq("err_set", 32'(credit_err), 32'd1);
        cm_redir_valid = 1'b1;
        cm_redir_pc    = 32'h80;
        tick();
        // cycle 37: mid-FLUSH
        cm_redir_valid = 1'b0;
        expect_eq("err_sticky", 32'(credit_err), 32'd1);
        expect_eq("rf_flush", 32'(flush_o), 32'd1);
        expect_eq("rf_cnt", 32'(redir_cnt), 32'd5);
        #2;
        reset = 1'b1;
        #1;
        expect_eq("rr_err", 32'(credit_err), 32'd0);
        expect_eq("rr_state", 32'(ctrl_state), 32'd0);
        expect_eq("rr_flush", 32'(flush_o), 32'd0);
        expect_eq("rr_pc", redirect_pc, 32'h0);
        expect_eq("rr_cnt", 32'(redir_cnt), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        tick();
        expect_eq("rr_idle", 32'(ctrl_state), 32'd0);
        expect_eq("rr_nofetch", 32'(fetch_en), 32'd0);
        expect_eq("rr_noflush", 32'(flush_o), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
